// File: rtl/lm75_poll_seq.sv
// ---------------------------------------------------------------------------
// lm75_poll_seq
//
// Periodic command sequencer for an I2C master that reads an LM75x
// temperature sensor.  Every POLL_CYCLES clocks (counted from the end of
// the previous transaction) it issues one read of pointer 0x00 (2 bytes),
// converts the result to a 9-bit signed temperature (0.5 degC/LSB) and
// retries failed transactions (NACK, missing ack, timeout) up to MAX_RETRY
// times before raising a sticky error flag.
//
// Optional feature (macro LM75_POLL_ALARM_EN): adds TOS/THYST parameters and
// an Alarm output with hysteresis, evaluated whenever Temp updates.
//
// Ports:
//   Clk_in       system clock
//   Rst          asynchronous active-high reset
//   Enable       polling runs while high
//   Ready        master idle / transaction complete
//   Error        master NACK flag, valid on the first Ready-high cycle
//   Data_out1/2  temperature MSB / LSB from the master
//   Start        one-cycle command pulse to the master
//   Adr          7-bit device address
//   Pointer      LM75 register pointer (always 0x00)
//   Set_pointer  master writes the pointer before reading
//   R_W          1 = read
//   Temp         signed temperature, 0.5 degC/LSB
//   Temp_valid   one-cycle pulse when Temp updates
//   Temp_err     sticky failure flag, cleared by the next good read
//   Busy         transaction in flight (including retry gaps)
//   Alarm        over-temperature flag (LM75_POLL_ALARM_EN only)
// ---------------------------------------------------------------------------
module lm75_poll_seq #(
    parameter logic [6:0]  DEV_ADR        = 7'b1001000,
    parameter int unsigned POLL_CYCLES    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned MAX_RETRY      = 2
`ifdef LM75_POLL_ALARM_EN
    ,
    parameter logic signed [8:0] TOS   = 9'sd160,
    parameter logic signed [8:0] THYST = 9'sd150
`endif
) (
    input  logic       Clk_in,
    input  logic       Rst,
    input  logic       Enable,
    input  logic       Ready,
    input  logic       Error,
    input  logic [7:0] Data_out1,
    input  logic [7:0] Data_out2,
    output logic       Start,
    output logic [6:0] Adr,
    output logic [7:0] Pointer,
    output logic       Set_pointer,
    output logic       R_W,
    output logic [8:0] Temp,
    output logic       Temp_valid,
    output logic       Temp_err,
    output logic       Busy
`ifdef LM75_POLL_ALARM_EN
    ,
    output logic       Alarm
`endif
);

    // Counter widths
    localparam int unsigned IntW = $clog2(POLL_CYCLES);
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 8) ? $clog2(TIMEOUT_CYCLES) : 3;
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IntW-1:0] IntLast = IntW'(POLL_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    // Ready still high on the 4th cycle after Start: master never took it
    localparam logic [TmoW-1:0] AckLast = TmoW'(3);
    localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StInterval,
        StIssue,
        StAckWait,
        StWaitDone,
        StRetryGap
    } state_e;

    state_e          state_q, state_d;
    logic [IntW-1:0] int_cnt_q, int_cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RtyW-1:0] retry_q, retry_d;
    logic [8:0]      temp_q, temp_d;
    logic            temp_valid_q, temp_valid_d;
    logic            temp_err_q, temp_err_d;
    // Set_pointer and R_W always move together for this read-only sequencer
    logic            cmd_q, cmd_d;

    logic            txn_ok;
    logic            txn_fail;
    logic [8:0]      new_temp;

    // Only the top bit of the LSB carries the 0.5 degC step
    assign new_temp = {Data_out1, Data_out2[7]};

    logic unused_lsb;
    assign unused_lsb = ^Data_out2[6:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        int_cnt_d    = int_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        retry_d      = retry_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        temp_err_d   = temp_err_q;
        cmd_d        = cmd_q;
        txn_ok       = 1'b0;
        txn_fail     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_d = 1'b0;
                if (Enable) begin
                    state_d   = StInterval;
                    int_cnt_d = '0;
                end
            end

            StInterval: begin
                if (!Enable) begin
                    state_d = StIdle;
                end else if (int_cnt_q == IntLast) begin
                    // Hold at terminal count until the master is idle
                    if (Ready) begin
                        state_d = StIssue;
                        cmd_d   = 1'b1;
                    end
                end else begin
                    int_cnt_d = int_cnt_q + 1'b1;
                end
            end

            StIssue: begin
                tmo_cnt_d = '0;
                state_d   = StAckWait;
            end

            StAckWait: begin
                if (!Ready) begin
                    state_d   = StWaitDone;
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end else if (tmo_cnt_q == AckLast) begin
                    txn_fail = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            StWaitDone: begin
                if (Ready) begin
                    if (Error) begin
                        txn_fail = 1'b1;
                    end else begin
                        txn_ok = 1'b1;
                    end
                end else if (tmo_cnt_q == TmoLast) begin
                    txn_fail = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            StRetryGap: begin
                if (Enable) begin
                    state_d = StIssue;
                end else begin
                    // Enable dropped between attempts: give up without retrying
                    state_d    = StIdle;
                    temp_err_d = 1'b1;
                    retry_d    = '0;
                    cmd_d      = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (txn_ok) begin
            temp_d       = new_temp;
            temp_valid_d = 1'b1;
            temp_err_d   = 1'b0;
            retry_d      = '0;
            cmd_d        = 1'b0;
            int_cnt_d    = '0;
            state_d      = Enable ? StInterval : StIdle;
        end

        if (txn_fail) begin
            if (Enable && (retry_q < RtyMax)) begin
                retry_d = retry_q + 1'b1;
                state_d = StRetryGap;
            end else begin
                // Final failure: Temp keeps its last good value
                temp_err_d = 1'b1;
                retry_d    = '0;
                cmd_d      = 1'b0;
                int_cnt_d  = '0;
                state_d    = Enable ? StInterval : StIdle;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state_q      <= StIdle;
            int_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            retry_q      <= '0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
            temp_err_q   <= 1'b0;
            cmd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_cnt_q    <= int_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_q      <= retry_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            temp_err_q   <= temp_err_d;
            cmd_q        <= cmd_d;
        end
    end

`ifdef LM75_POLL_ALARM_EN
    logic alarm_q, alarm_d;

    // Evaluated against the value being loaded into Temp so Alarm changes
    // in the same cycle as the Temp_valid pulse.
    always_comb begin
        alarm_d = alarm_q;
        if (txn_ok) begin
            if ($signed(new_temp) >= TOS) begin
                alarm_d = 1'b1;
            end else if ($signed(new_temp) < THYST) begin
                alarm_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign Alarm = alarm_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Start       = (state_q == StIssue);
    assign Busy        = (state_q == StIssue) || (state_q == StAckWait) ||
                         (state_q == StWaitDone) || (state_q == StRetryGap);
    assign Adr         = DEV_ADR;
    assign Pointer     = 8'h00;
    assign Set_pointer = cmd_q;
    assign R_W         = cmd_q;
    assign Temp        = temp_q;
    assign Temp_valid  = temp_valid_q;
    assign Temp_err    = temp_err_q;

endmodule

// File: tb/tb_lm75_poll_seq.sv
// ---------------------------------------------------------------------------
// tb_lm75_poll_seq
//
// Directed bench for lm75_poll_seq with a small behavioural I2C master /
// LM75 model.  A table of poll outcomes (data bytes, number of NACKs,
// expected Start count, Temp, Temp_valid, Temp_err and Start spacing) is
// applied in a loop; timeout, Enable-drop and mid-transaction reset are
// covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_lm75_poll_seq;

    localparam int unsigned PollCycles    = 100;
    localparam int unsigned TimeoutCycles = 50;
    localparam int unsigned MaxRetry      = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ready;
    logic       error;
    logic [7:0] d_out1;
    logic [7:0] d_out2;
    logic       start;
    logic [6:0] adr;
    logic [7:0] pointer;
    logic       set_pointer;
    logic       r_w;
    logic [8:0] temp;
    logic       temp_valid;
    logic       temp_err;
    logic       busy;
`ifdef LM75_POLL_ALARM_EN
    logic       alarm;
`endif

    always #5 clk = ~clk;

    lm75_poll_seq #(
        .DEV_ADR       (7'h48),
        .POLL_CYCLES   (PollCycles),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .MAX_RETRY     (MaxRetry)
    ) dut (
        .Clk_in     (clk),
        .Rst        (rst),
        .Enable     (enable),
        .Ready      (ready),
        .Error      (error),
        .Data_out1  (d_out1),
        .Data_out2  (d_out2),
        .Start      (start),
        .Adr        (adr),
        .Pointer    (pointer),
        .Set_pointer(set_pointer),
        .R_W        (r_w),
        .Temp       (temp),
        .Temp_valid (temp_valid),
        .Temp_err   (temp_err),
        .Busy       (busy)
`ifdef LM75_POLL_ALARM_EN
        ,
        .Alarm      (alarm)
`endif
    );

    // Cycle counter (posedges seen)
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Master / LM75 model: accepts Start while Ready, drops Ready, then
    // raises it after lat cycles with the scripted bytes.  Transactions
    // numbered below nack_limit return Error=1.  hang freezes Ready low.
    // ------------------------------------------------------------------
    int         lat        = 4;
    bit         hang       = 1'b0;
    logic [7:0] m_d1       = 8'h00;
    logic [7:0] m_d2       = 8'h00;
    int         nack_limit = 0;
    int         txn_cnt    = 0;
    int         busy_cnt   = 0;

    always @(negedge clk) begin
        if (rst) begin
            ready    = 1'b1;
            error    = 1'b0;
            busy_cnt = 0;
            d_out1   = 8'h00;
            d_out2   = 8'h00;
        end else if (ready) begin
            if (start) begin
                ready    = 1'b0;
                busy_cnt = lat;
            end
        end else if (!hang) begin
            if (busy_cnt > 1) begin
                busy_cnt = busy_cnt - 1;
            end else begin
                ready   = 1'b1;
                d_out1  = m_d1;
                d_out2  = m_d2;
                error   = (txn_cnt < nack_limit);
                txn_cnt = txn_cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers (all driven from the single initial process)
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int fall_cnt = 0;
    int last_fall_cyc = 0;
    int first_gap = 0;
    int first_start_cyc = 0;
    bit gap_armed = 1'b0;
    bit start_prev = 1'b0;
    bit busy_prev = 1'b0;
    bit tv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next negedge and track Start/Busy/Temp_valid events
    task automatic step();
        @(negedge clk);
        if (start_prev) check("start_pulse_len", 32'(start), 32'h0);
        if (tv_prev) check("valid_pulse_len", 32'(temp_valid), 32'h0);
        if (start && !start_prev) begin
            start_cnt = start_cnt + 1;
            check("start_cmd", {15'd0, adr, pointer, set_pointer, r_w},
                  {15'd0, 7'h48, 8'h00, 1'b1, 1'b1});
            if (gap_armed) begin
                first_gap       = cyc - last_fall_cyc;
                first_start_cyc = cyc;
                gap_armed       = 1'b0;
            end
        end
        if (busy_prev && !busy) begin
            fall_cnt      = fall_cnt + 1;
            last_fall_cyc = cyc;
        end
        start_prev = start;
        busy_prev  = busy;
        tv_prev    = temp_valid;
    endtask

    task automatic wait_fall(input int budget, input string name);
        int  f0;
        bit  got;
        f0  = fall_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (fall_cnt != f0) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 32'h1);
    endtask

    task automatic wait_start(input int budget, input string name);
        int  s0;
        bit  got;
        s0  = start_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (start_cnt != s0) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 32'h1);
    endtask

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        int         nacks;
        int         exp_starts;
        logic [8:0] exp_temp;
        logic       exp_valid;
        logic       exp_err;
        int         exp_gap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s0;

        vecs[0] = '{8'h19, 8'h80, 0, 1, 9'h033, 1'b1, 1'b0, 101}; // 25.5 degC
        vecs[1] = '{8'hE7, 8'h00, 0, 1, 9'h1CE, 1'b1, 1'b0, 100}; // -25 degC
        vecs[2] = '{8'h32, 8'h00, 1, 2, 9'h064, 1'b1, 1'b0, 100}; // one NACK
        vecs[3] = '{8'h7F, 8'h80, 3, 3, 9'h064, 1'b0, 1'b1, 100}; // retries exhausted
        vecs[4] = '{8'h00, 8'h80, 0, 1, 9'h001, 1'b1, 1'b0, 100}; // clears Temp_err
        vecs[5] = '{8'hFF, 8'h80, 2, 3, 9'h1FF, 1'b1, 1'b0, 100}; // last retry wins

        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) step();

        check("rst_start", 32'(start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_temp", 32'(temp), 32'h0);
        check("rst_valid", 32'(temp_valid), 32'h0);
        check("rst_err", 32'(temp_err), 32'h0);
        check("rst_cmd", {30'd0, set_pointer, r_w}, 32'h0);
        check("rst_adr_ptr", {17'd0, adr, pointer}, {17'd0, 7'h48, 8'h00});

        rst           = 1'b0;
        last_fall_cyc = cyc;
        gap_armed     = 1'b1;
        s0            = start_cnt;
        repeat (PollCycles) step();
        check("no_early_start", 32'(start_cnt - s0), 32'h0);

        // Table-driven poll outcomes
        for (int i = 0; i < 6; i++) begin
            m_d1       = vecs[i].d1;
            m_d2       = vecs[i].d2;
            nack_limit = txn_cnt + vecs[i].nacks;
            if (i > 0) gap_armed = 1'b1;
            s0 = start_cnt;
            wait_fall(2000, "vec_done");
            check("vec_starts", 32'(start_cnt - s0), 32'(vecs[i].exp_starts));
            check("vec_temp", 32'(temp), 32'(vecs[i].exp_temp));
            check("vec_valid", 32'(temp_valid), 32'(vecs[i].exp_valid));
            check("vec_err", 32'(temp_err), 32'(vecs[i].exp_err));
            check("vec_gap", 32'(first_gap), 32'(vecs[i].exp_gap));
        end

        // Timeout: Ready stays low after every Start
        hang      = 1'b1;
        gap_armed = 1'b1;
        s0        = start_cnt;
        wait_fall(1000, "tmo_done");
        check("tmo_starts", 32'(start_cnt - s0), 32'd3);
        check("tmo_err", 32'(temp_err), 32'h1);
        check("tmo_temp_held", 32'(temp), 32'h1FF);
        check("tmo_valid", 32'(temp_valid), 32'h0);
        check("tmo_duration", 32'(last_fall_cyc - first_start_cyc), 32'd155);
        hang = 1'b0;

        // Enable dropped mid-transaction: read completes, then no more Starts
        lat  = 30;
        m_d1 = 8'h1E;
        m_d2 = 8'h80;
        wait_start(400, "en_start");
        enable = 1'b0;
        wait_fall(200, "en_done");
        check("en_valid", 32'(temp_valid), 32'h1);
        check("en_temp", 32'(temp), 32'h03D);
        check("en_err_cleared", 32'(temp_err), 32'h0);
        s0 = start_cnt;
        repeat (300) step();
        check("en_no_start", 32'(start_cnt - s0), 32'h0);
        check("en_idle", 32'(busy), 32'h0);

        // Reset while waiting for completion
        enable = 1'b1;
        m_d1   = 8'h28;
        m_d2   = 8'h00;
        wait_start(400, "rst2_start");
        repeat (5) step();
        check("rst2_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("rst2_busy", 32'(busy), 32'h0);
        check("rst2_start", 32'(start), 32'h0);
        check("rst2_temp", 32'(temp), 32'h0);
        check("rst2_cmd", {30'd0, set_pointer, r_w}, 32'h0);
        check("rst2_flags", {30'd0, temp_valid, temp_err}, 32'h0);
        step();
        step();
        rst           = 1'b0;
        last_fall_cyc = cyc;
        gap_armed     = 1'b1;
        s0            = start_cnt;
        lat           = 4;
        wait_fall(400, "rst2_done");
        check("rst2_starts", 32'(start_cnt - s0), 32'd1);
        check("rst2_gap", 32'(first_gap), 32'd101);
        check("rst2_temp_new", 32'(temp), 32'h050);
        check("rst2_valid", 32'(temp_valid), 32'h1);

`ifdef LM75_POLL_ALARM_EN
        begin
            logic [7:0] a_d1[3];
            logic [7:0] a_d2[3];
            logic       a_exp[3];
            a_d1[0] = 8'h50; a_d2[0] = 8'h00; a_exp[0] = 1'b1; // 160
            a_d1[1] = 8'h4D; a_d2[1] = 8'h80; a_exp[1] = 1'b1; // 155
            a_d1[2] = 8'h4A; a_d2[2] = 8'h80; a_exp[2] = 1'b0; // 149
            for (int i = 0; i < 3; i++) begin
                m_d1 = a_d1[i];
                m_d2 = a_d2[i];
                wait_fall(400, "alarm_done");
                check("alarm_valid", 32'(temp_valid), 32'h1);
                check("alarm", 32'(alarm), 32'(a_exp[i]));
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
